bound_flasher_seq: RTL and testbench
====================================

Name: bound_flasher_seq

Overview:
- Parametrised, self-contained successor to the bound-flasher next-state logic. Holds the main-state register, the lit-LED counter and the thermometer LED output in one block.
- Runs the three-wave flasher sequence: up to PEAK0, down to FLOOR0, up to PEAK1, down to FLOOR1, up to PEAK2, down to 0.
- Bounds, LED count and kickback points are parameters, not constants.
- Sits between the flick input synchroniser and the LED pad drivers. It reports busy/done to the top level.

Parameters:
- N_LED, 16, number of LEDs; led width.
- PEAK0, 15, highest LED index lit in wave 0.
- FLOOR0, 5, count at which down-phase 0 ends.
- PEAK1, 10, highest LED index lit in wave 1.
- FLOOR1, 0, count at which down-phase 1 ends.
- PEAK2, 5, highest LED index lit in wave 2.
- KB_A, 5, first kickback count.
- KB_B, 0, second kickback count.
- CW, $clog2(N_LED+1), counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flick  in  1  start / kickback request, already synchronised.
- led  out  N_LED  thermometer output: led[i]=1 iff i<count.
- state  out  3  current main state, for debug.
- count  out  CW  current lit-LED count.
- busy  out  1  high whenever state != INIT.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (async, rst_n=0): state=INIT, count=0, led=0, done=0, busy=0. Reset mid-sequence aborts immediately; no resume.
- States (3-bit): INIT=0, UP0=1, DN0=2, UP1=3, DN1=4, UP2=5, DN2=6. Codes 7 and above return to INIT with count loaded 0.
- All registers update on the same rising edge.
  - Counter direction comes from the NEXT state: UPx → +1, DNx → −1, INIT → hold.
  - An immediate load overrides the direction.
- Transitions, evaluated on the current state and count:
  - INIT: flick=1 → UP0.
  - UP0: count==PEAK0+1 → DN0.
  - DN0: kickback → load PEAK0+1, stay in DN0. Otherwise count==FLOOR0 → UP1.
  - UP1: count==PEAK1+1 → DN1.
  - DN1: kickback → load PEAK1+1, stay in DN1. Otherwise count==FLOOR1 → UP2.
  - UP2: count==PEAK2+1 → DN2.
  - DN2: count==0 → INIT, load 0, done=1 for the next cycle. Kickback is not honoured in DN2.
- Kickback = flick && (count==KB_A || count==KB_B), in DN0/DN1 only. Kickback has priority over the floor exit when both hit the same cycle.
- flick is ignored in UPx, in DN2, and in DN0/DN1 at non-kickback counts. flick held high at sequence end restarts only after one cycle in INIT.
- Count never wraps; legal parameters guarantee this.
- Elaboration-time assertions: PEAK0<N_LED, FLOOR0<=PEAK0, FLOOR1<FLOOR0<=PEAK1+1, PEAK2<N_LED, PEAK1<N_LED.
- Default sequence, with edge 1 being the one that samples flick in INIT:
  - edges 1–16: count 1..16 (UP0).
  - edge 17: count 15, DN0.
  - edge 27: count 5.
  - edge 28: count 6, UP1.
  - edge 33: count 11.
  - edge 34: count 10, DN1.
  - edge 44: count 0.
  - edge 45: count 1, UP2.
  - edge 50: count 6.
  - edge 51: count 5, DN2.
  - edge 56: count 0.
  - edge 57: INIT, done=1 for one cycle.
- led is a combinational decode of the count register, so it is glitch-free relative to clk.

Optional Feature:
- Macro BF_AUTO_REPEAT_EN.
- Defined: adds input auto_repeat (1 bit).
  - DN2 exit with auto_repeat=1 → UP0 directly, count loaded 1; done still pulses.
  - DN2 exit with auto_repeat=0 → INIT as in the base behaviour.
- Undefined: the port is absent and DN2 always exits to INIT.

Test Plan:
- Reset, then flick pulsed one cycle in INIT → count follows the edge-1..57 trajectory above; done high only in cycle 58; busy high for cycles 2..57.
- flick held high throughout DN0 → reload to 16 at count 5, repeated on each pass; never reaches UP1 while flick stays high.
- flick pulsed at DN1 count 5 → count reloads to 11, then decrements 10..0; flick again at count 0 → reload to 11; no flick → UP2 at count 1.
- flick asserted in UP0, UP1, DN2 and at DN0 count 9 → no change from the nominal trajectory.
- rst_n low for one cycle at DN1 count 7 → immediately state=0, count=0, led=0; restart needs a new flick.
- Parameter set N_LED=8, PEAK0=7, FLOOR0=3, PEAK1=5, FLOOR1=0, PEAK2=2, KB_A=3 → peaks 8/6/3 and floors 3/0/0; with BF_AUTO_REPEAT_EN and auto_repeat=1, count goes 0→1 at the DN2 exit with no INIT cycle.

Source files
------------

// File: rtl/bound_flasher_seq.sv
`timescale 1ns/1ps
// bound_flasher_seq
// Three-wave bound-flasher sequencer: main-state register, lit-LED counter
// and thermometer LED decode in one block. The count climbs to PEAK0+1,
// falls to FLOOR0, climbs to PEAK1+1, falls to FLOOR1, climbs to PEAK2+1 and
// falls to 0. A flick at a kickback count in DN0/DN1 reloads that wave's top.
//
// Optional feature macro: BF_AUTO_REPEAT_EN (adds input auto_repeat; a DN2
// exit with auto_repeat=1 restarts UP0 directly at count 1).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   flick        in   start / kickback request, already synchronised
//   auto_repeat  in   (BF_AUTO_REPEAT_EN only) loop back to UP0 at DN2 exit
//   led          out  thermometer decode: led[i]=1 iff i<count
//   state        out  current main state (debug)
//   count        out  current lit-LED count
//   busy         out  high whenever state != INIT
//   done         out  one-cycle pulse after the sequence completes
module bound_flasher_seq #(
  parameter int unsigned N_LED  = 16,
  parameter int unsigned PEAK0  = 15,
  parameter int unsigned FLOOR0 = 5,
  parameter int unsigned PEAK1  = 10,
  parameter int unsigned FLOOR1 = 0,
  parameter int unsigned PEAK2  = 5,
  parameter int unsigned KB_A   = 5,
  parameter int unsigned KB_B   = 0,
  parameter int unsigned CW     = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
`ifdef BF_AUTO_REPEAT_EN
  input  logic             auto_repeat,
`endif
  output logic [N_LED-1:0] led,
  output logic [2:0]       state,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_UP0  = 3'd1;
  localparam logic [2:0] S_DN0  = 3'd2;
  localparam logic [2:0] S_UP1  = 3'd3;
  localparam logic [2:0] S_DN1  = 3'd4;
  localparam logic [2:0] S_UP2  = 3'd5;
  localparam logic [2:0] S_DN2  = 3'd6;

  // Turn-around counts: an up-phase ends one above its highest lit index.
  localparam logic [CW-1:0] C_TOP0   = CW'(PEAK0 + 1);
  localparam logic [CW-1:0] C_TOP1   = CW'(PEAK1 + 1);
  localparam logic [CW-1:0] C_TOP2   = CW'(PEAK2 + 1);
  localparam logic [CW-1:0] C_FLOOR0 = CW'(FLOOR0);
  localparam logic [CW-1:0] C_FLOOR1 = CW'(FLOOR1);
  localparam logic [CW-1:0] C_KB_A   = CW'(KB_A);
  localparam logic [CW-1:0] C_KB_B   = CW'(KB_B);

  // Elaboration-time parameter legality checks.
  if (PEAK0 >= N_LED) begin : g_bad_peak0
    $error("bound_flasher_seq: PEAK0 must be below N_LED");
  end
  if (FLOOR0 > PEAK0) begin : g_bad_floor0
    $error("bound_flasher_seq: FLOOR0 must not exceed PEAK0");
  end
  if (!((FLOOR1 < FLOOR0) && (FLOOR0 <= PEAK1 + 1))) begin : g_bad_floor1
    $error("bound_flasher_seq: need FLOOR1 < FLOOR0 <= PEAK1+1");
  end
  if (PEAK1 >= N_LED) begin : g_bad_peak1
    $error("bound_flasher_seq: PEAK1 must be below N_LED");
  end
  if (PEAK2 >= N_LED) begin : g_bad_peak2
    $error("bound_flasher_seq: PEAK2 must be below N_LED");
  end

  logic [2:0]       r_state;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_state_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_load;
  logic [CW-1:0]    w_load_val;
  logic             w_done_nxt;
  logic             w_busy_nxt;
  logic             w_kick;
  logic             w_auto_rep;
  logic [N_LED-1:0] w_led;

`ifdef BF_AUTO_REPEAT_EN
  assign w_auto_rep = auto_repeat;
`else
  assign w_auto_rep = 1'b0;
`endif

  // Kickback request; only the DN0/DN1 branches below act on it.
  assign w_kick = flick && ((r_count == C_KB_A) || (r_count == C_KB_B));

  // State, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic plus immediate counter loads.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_INIT: begin
        if (flick) w_state_nxt = S_UP0;
      end
      S_UP0: begin
        if (r_count == C_TOP0) w_state_nxt = S_DN0;
      end
      S_DN0: begin
        // Kickback wins over the floor exit.
        if (w_kick) begin
          w_load     = 1'b1;
          w_load_val = C_TOP0;
        end else if (r_count == C_FLOOR0) begin
          w_state_nxt = S_UP1;
        end
      end
      S_UP1: begin
        if (r_count == C_TOP1) w_state_nxt = S_DN1;
      end
      S_DN1: begin
        if (w_kick) begin
          w_load     = 1'b1;
          w_load_val = C_TOP1;
        end else if (r_count == C_FLOOR1) begin
          w_state_nxt = S_UP2;
        end
      end
      S_UP2: begin
        if (r_count == C_TOP2) w_state_nxt = S_DN2;
      end
      S_DN2: begin
        if (r_count == '0) begin
          w_done_nxt = 1'b1;
          w_load     = 1'b1;
          if (w_auto_rep) begin
            w_state_nxt = S_UP0;
            w_load_val  = CW'(1);
          end else begin
            w_state_nxt = S_INIT;
          end
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_load      = 1'b1;
      end
    endcase
  end

  // Counter direction follows the next state; a load overrides it.
  always_comb begin
    w_count_nxt = r_count;
    if (w_load) begin
      w_count_nxt = w_load_val;
    end else begin
      case (w_state_nxt)
        S_UP0, S_UP1, S_UP2: w_count_nxt = r_count + CW'(1);
        S_DN0, S_DN1, S_DN2: w_count_nxt = r_count - CW'(1);
        default:             w_count_nxt = r_count;
      endcase
    end
    w_busy_nxt = (w_state_nxt != S_INIT);
    w_led = '0;
    for (int i = 0; i < N_LED; i++) begin
      w_led[i] = (CW'(i) < r_count);
    end
  end

  assign led   = w_led;
  assign state = r_state;
  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_bound_flasher_seq.sv
`timescale 1ns/1ps
// Directed bench for bound_flasher_seq: default-parameter instance plus a
// small 8-LED instance, expected trajectories written out by hand.
module tb_bound_flasher_seq;

`ifdef BF_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flick;
  logic        f8;
  logic [15:0] led;
  logic [2:0]  state;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic [7:0]  led8;
  logic [2:0]  state8;
  logic [3:0]  cnt8;
  logic        busy8;
  logic        done8;
`ifdef BF_AUTO_REPEAT_EN
  logic        ar;
  logic        ar8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bound_flasher_seq u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flick       (flick),
`ifdef BF_AUTO_REPEAT_EN
    .auto_repeat (ar),
`endif
    .led         (led),
    .state       (state),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  bound_flasher_seq #(
    .N_LED (8), .PEAK0 (7), .FLOOR0 (3), .PEAK1 (5),
    .FLOOR1 (0), .PEAK2 (2), .KB_A (3), .KB_B (0)
  ) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flick       (f8),
`ifdef BF_AUTO_REPEAT_EN
    .auto_repeat (ar8),
`endif
    .led         (led8),
    .state       (state8),
    .count       (cnt8),
    .busy        (busy8),
    .done        (done8)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flick = 1'b0;
    f8    = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] thermo(input int c);
    return (32'd1 << c) - 32'd1;
  endfunction

  // Default trajectory after edge e (edge 1 samples flick in INIT).
  function automatic int exp_cnt(input int e);
    if (e <= 16)      return e;
    else if (e <= 27) return 32 - e;
    else if (e <= 33) return e - 22;
    else if (e <= 44) return 44 - e;
    else if (e <= 50) return e - 44;
    else if (e <= 56) return 56 - e;
    else              return 0;
  endfunction

  function automatic int exp_st(input int e);
    if (e <= 16)      return 1;
    else if (e <= 27) return 2;
    else if (e <= 33) return 3;
    else if (e <= 44) return 4;
    else if (e <= 50) return 5;
    else if (e <= 56) return 6;
    else              return 0;
  endfunction

  // Runs edges 1..last_e from INIT; noisy adds flicks that must be ignored.
  task automatic run_nominal(input int last_e, input bit noisy);
    for (int e = 1; e <= last_e; e++) begin
      flick = (e == 1) || (noisy && (e == 6 || e == 24 || e == 31 || e == 54 || e == 57));
      tick();
      check_eq($sformatf("cnt e%0d", e), 32'(count), 32'(exp_cnt(e)));
      check_eq($sformatf("st e%0d", e), 32'(state), 32'(exp_st(e)));
      check_eq($sformatf("led e%0d", e), 32'(led), thermo(exp_cnt(e)));
      check_eq($sformatf("busy e%0d", e), 32'(busy), 32'(e < 57));
      check_eq($sformatf("done e%0d", e), 32'(done), 32'(e == 57));
    end
    flick = 1'b0;
  endtask

  int exp8_c [29] = '{1,2,3,4,5,6,7,8,7,6,5,4,3,4,5,6,5,4,3,2,1,0,1,2,3,2,1,0,0};
  int exp8_s [29] = '{1,1,1,1,1,1,1,1,2,2,2,2,2,3,3,3,4,4,4,4,4,4,5,5,5,6,6,6,0};

  initial begin
    rst_n = 1'b0;
    flick = 1'b0;
    f8    = 1'b0;
`ifdef BF_AUTO_REPEAT_EN
    ar    = 1'b0;
    ar8   = 1'b1;
`endif
    #12;
    check_eq("rst state", 32'(state), 32'd0);
    check_eq("rst count", 32'(count), 32'd0);
    check_eq("rst led", 32'(led), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle state", 32'(state), 32'd0);
    check_eq("idle count", 32'(count), 32'd0);

    // Full nominal sequence, then done must drop.
    run_nominal(57, 1'b0);
    tick();
    check_eq("e58 done", 32'(done), 32'd0);
    check_eq("e58 state", 32'(state), 32'd0);
    check_eq("e58 count", 32'(count), 32'd0);

    // flick held through DN0: reload to 16 at count 5 on every pass.
    do_reset();
    run_nominal(16, 1'b0);
    flick = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      check_eq($sformatf("kb0 cnt k%0d", k), 32'(count),
               ((k % 12) == 11) ? 32'd16 : 32'(15 - (k % 12)));
      check_eq($sformatf("kb0 st k%0d", k), 32'(state), 32'd2);
    end
    flick = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      check_eq($sformatf("kb0 tail k%0d", k), 32'(count), 32'(15 - k));
    end
    tick();
    check_eq("kb0 up1 st", 32'(state), 32'd3);
    check_eq("kb0 up1 cnt", 32'(count), 32'd6);

    // DN1 kickback at count 5 and again at count 0.
    do_reset();
    run_nominal(39, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      flick = 1'b1;
      tick();
      flick = 1'b0;
      check_eq($sformatf("kb1 reload p%0d", pass), 32'(count), 32'd11);
      check_eq($sformatf("kb1 st p%0d", pass), 32'(state), 32'd4);
      for (int k = 1; k <= 11; k++) begin
        tick();
        check_eq($sformatf("kb1 p%0d k%0d", pass, k), 32'(count), 32'(11 - k));
      end
    end
    tick();
    check_eq("kb1 up2 st", 32'(state), 32'd5);
    check_eq("kb1 up2 cnt", 32'(count), 32'd1);

    // Ignored flicks, then flick held at sequence end restarts after INIT.
    do_reset();
    run_nominal(57, 1'b1);
    flick = 1'b1;
    tick();
    flick = 1'b0;
    check_eq("restart st", 32'(state), 32'd1);
    check_eq("restart cnt", 32'(count), 32'd1);
    check_eq("restart done", 32'(done), 32'd0);

    // Asynchronous reset mid-DN1 at count 7.
    do_reset();
    run_nominal(37, 1'b0);
    rst_n = 1'b0;
    #2;
    check_eq("abort st", 32'(state), 32'd0);
    check_eq("abort cnt", 32'(count), 32'd0);
    check_eq("abort led", 32'(led), 32'd0);
    check_eq("abort busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("abort idle st", 32'(state), 32'd0);
    check_eq("abort idle cnt", 32'(count), 32'd0);
    flick = 1'b1;
    tick();
    flick = 1'b0;
    check_eq("abort restart", 32'(count), 32'd1);

    // Small parameter set.
    do_reset();
    for (int e = 1; e <= 29; e++) begin
      f8 = (e == 1);
      tick();
      check_eq($sformatf("p8 cnt e%0d", e), 32'(cnt8),
               (e == 29 && AR) ? 32'd1 : 32'(exp8_c[e-1]));
      check_eq($sformatf("p8 st e%0d", e), 32'(state8),
               (e == 29 && AR) ? 32'd1 : 32'(exp8_s[e-1]));
      check_eq($sformatf("p8 led e%0d", e), 32'(led8),
               (e == 29 && AR) ? 32'd1 : thermo(exp8_c[e-1]));
      check_eq($sformatf("p8 done e%0d", e), 32'(done8), 32'(e == 29));
    end
    f8 = 1'b0;
    check_eq("p8 busy end", 32'(busy8), 32'(AR));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
